alu_issue_unit: RTL and testbench
=================================

Name: alu_issue_unit

Overview:
Upstream issue/writeback stage for the 8-bit ALU. It accepts instruction bytes over a valid/ready stream and decodes the 4-bit opcode. It fetches a second immediate byte when needed, drives registered x/y/operation to the ALU, then captures the ALU result into the accumulator and latches the flags. It owns a small operand register file (r0..rN-1) plus the accumulator, and supplies the ALU's x operand (accumulator) and y operand (register or immediate).

Parameters:
NUM_REGS, 4, number of 8-bit operand registers; index width = clog2(NUM_REGS), max 4 (fits instr[1:0]..instr[3:0]).
ACC_INIT, 8'h00, accumulator value after reset.

Ports:
clock  input  1  single clock; all state updates on rising edge.
reset  input  1  synchronous, active-low reset (clock and reset are the only clock/reset ports).
instr_valid  input  1  instruction byte available.
instr_data  input  8  instruction byte: [7:4] opcode, [3:0] register index (low bits used) or immediate value.
instr_ready  output  1  unit accepts instr_data this cycle.
reg_we  input  1  external register-file write enable.
reg_waddr  input  clog2(NUM_REGS)  write index.
reg_wdata  input  8  write data.
alu_x  output  8  ALU x operand (registered).
alu_y  output  8  ALU y operand (registered).
alu_operation  output  4  ALU operation code (registered).
alu_out  input  16  ALU result; bits [7:0] used.
alu_flags  input  4  ALU flags; CARRY_FLAG and NEG_FLAG bits used.
acc  output  8  accumulator.
flags  output  4  latched flags {spare, neg, zero, carry} by package indices.
done  output  1  one-cycle pulse on writeback.
illegal  output  1  one-cycle pulse when an illegal opcode is consumed.
busy  output  1  high in every state except FETCH_OP.

Behaviour:
- Opcode encoding: SUM=0, SMI=1, SB=2, SBI=3, CM=4, CMI=5, ANR=6, ANI=7, ORR=8, ORI=9, XRR=10, XRI=11. Odd opcode = immediate form. 12..15 are illegal.
- Reset (reset==0 at an edge): state=FETCH_OP; acc=ACC_INIT; flags=0; all registers=0; alu_x/alu_y/alu_operation=0; done=0; illegal=0; instr_ready=0 during the reset cycle. Reset aborts any in-flight instruction with no writeback.
- FSM: FETCH_OP -> FETCH_IMM (immediate form) or EXECUTE (register form) or FETCH_OP (illegal, illegal=1 next cycle). FETCH_IMM -> EXECUTE. EXECUTE -> WRITEBACK. WRITEBACK -> FETCH_OP.
- instr_ready=1 only in FETCH_OP and FETCH_IMM. A byte is consumed only when instr_valid&&instr_ready. The FSM stalls indefinitely while instr_valid=0.
- Operand capture at the edge leaving FETCH_OP (register form) or FETCH_IMM (immediate form): alu_x<=acc, alu_operation<=opcode, alu_y<=reg[idx] or immediate byte. CM/CMI capture y as normal; the ALU ignores it.
- EXECUTE: operands stable for one cycle; the ALU is combinational.
- Writeback at the edge leaving WRITEBACK: acc<=alu_out[7:0]; flags[CARRY]<=alu_flags[CARRY]; flags[NEG]<=alu_flags[NEG]; flags[ZERO]<=(alu_out[7:0]==0) (computed here, not by the ALU); spare bit=0. done pulses high for the following cycle.
- Latency: register form, opcode accept to acc update = 3 edges; immediate form = 3 edges after immediate accept. Peak throughput is 1 instruction per 3 cycles (register) or 4 cycles (immediate).
- Register write vs. capture in the same cycle at the same index: the captured y is the old value; the write completes normally. Writes are allowed in any state.
- Illegal opcode: consumed, acc/flags unchanged, illegal pulses for one cycle.

Decomposition:
- Shared package (opcodes.v): opcode constants ALU_SUM..ALU_XRI, flag indices CARRY_FLAG=0, ZERO_FLAG=1, NEG_FLAG=2, FSM state encodings.
- One sub-module: alu_regfile, holding NUM_REGS x 8 registers with 1 write port, 1 async read port and synchronous active-low reset.

Test Plan:
- Reset, r1<=8'h0F, then bytes 0x10,0xFF (SMI 0xFF) -> acc=0xFF, flags carry=0 zero=0 neg=1, done pulse exactly 3 edges after the 0xFF is accepted.
- Follow with 0x10,0x01 -> alu_out=0x100, acc=0x00, carry=1 zero=1 neg=0.
- acc=0xF0, byte 0x61 (ANR r1, r1=0x0F) -> acc=0x00, zero=1, carry=0; alu_y observed=0x0F in EXECUTE.
- Byte 0xC3 -> illegal pulse one cycle, acc/flags unchanged, instr_ready back high the next cycle.
- Drop instr_valid for 5 cycles between the SMI opcode and its immediate -> remains in FETCH_IMM with busy=1 and no done; completes normally once the immediate arrives.
- Assert reset low in EXECUTE -> next cycle acc=ACC_INIT, flags=0, done never pulses, state FETCH_OP. Same-index reg_we during operand capture -> y takes the old value.

Source files
------------

// File: rtl/alu_issue_unit_pkg.sv
// Shared definitions for the ALU issue/writeback stage: opcodes, flag bit
// positions, FSM state encodings and small decode helpers.
package alu_issue_unit_pkg;

    localparam logic [3:0] ALU_SUM = 4'd0;
    localparam logic [3:0] ALU_SMI = 4'd1;
    localparam logic [3:0] ALU_SB  = 4'd2;
    localparam logic [3:0] ALU_SBI = 4'd3;
    localparam logic [3:0] ALU_CM  = 4'd4;
    localparam logic [3:0] ALU_CMI = 4'd5;
    localparam logic [3:0] ALU_ANR = 4'd6;
    localparam logic [3:0] ALU_ANI = 4'd7;
    localparam logic [3:0] ALU_ORR = 4'd8;
    localparam logic [3:0] ALU_ORI = 4'd9;
    localparam logic [3:0] ALU_XRR = 4'd10;
    localparam logic [3:0] ALU_XRI = 4'd11;

    localparam int CARRY_FLAG = 0;
    localparam int ZERO_FLAG  = 1;
    localparam int NEG_FLAG   = 2;
    localparam int SPARE_FLAG = 3;

    localparam logic [1:0] FETCH_OP  = 2'd0;
    localparam logic [1:0] FETCH_IMM = 2'd1;
    localparam logic [1:0] EXECUTE   = 2'd2;
    localparam logic [1:0] WRITEBACK = 2'd3;

    typedef struct packed {
        logic [3:0] opcode;
        logic [3:0] operand;
    } instr_t;

    function automatic logic is_illegal(input logic [3:0] op);
        return op > ALU_XRI;
    endfunction

    // Odd opcodes carry their y operand in a second instruction byte.
    function automatic logic is_imm(input logic [3:0] op);
        return op[0];
    endfunction

endpackage

// File: rtl/alu_issue_unit_if.sv
// Instruction byte stream plus the operand/result bus to the ALU.
interface alu_issue_unit_if;
    logic       instr_valid;
    logic [7:0] instr_data;
    logic       instr_ready;
    logic [7:0] alu_x;
    logic [7:0] alu_y;
    logic [3:0] alu_operation;
    logic [15:0] alu_out;
    logic [3:0] alu_flags;

    modport master (
        output instr_valid, instr_data, alu_out, alu_flags,
        input  instr_ready, alu_x, alu_y, alu_operation
    );

    modport slave (
        input  instr_valid, instr_data, alu_out, alu_flags,
        output instr_ready, alu_x, alu_y, alu_operation
    );
endinterface

// File: rtl/alu_issue_unit_regfile.sv
// Operand register file: one write port, one asynchronous read port.
module alu_regfile #(
    parameter int NUM_REGS = 4,
    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [7:0]       wdata,
    input  logic [IDX_W-1:0] raddr,
    output logic [7:0]       rdata
);

    logic [NUM_REGS-1:0][7:0] regs;

    always_ff @(posedge clock) begin
        if (!reset) begin
            regs <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (we && waddr == IDX_W'(i))
                    regs[i] <= wdata;
            end
        end
    end

    assign rdata = regs[raddr];

endmodule

// File: rtl/alu_issue_unit.sv
// Issue/writeback stage for the 8-bit ALU: fetches instruction bytes, drives
// registered operands, and writes the ALU result back into the accumulator.
module alu_issue_unit
    import alu_issue_unit_pkg::*;
#(
    parameter int         NUM_REGS = 4,
    parameter logic [7:0] ACC_INIT = 8'h00,
    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic              clock,
    input  logic              reset,
    alu_issue_unit_if.slave   bus,
    input  logic              reg_we,
    input  logic [IDX_W-1:0]  reg_waddr,
    input  logic [7:0]        reg_wdata,
    output logic [7:0]        acc,
    output logic [3:0]        flags,
    output logic              done,
    output logic              illegal,
    output logic              busy
);

    logic [1:0] state;
    logic [3:0] pend_op;
    logic [7:0] rdata;
    logic       accept;
    instr_t     ins;

    assign ins = bus.instr_data;

    alu_regfile #(.NUM_REGS(NUM_REGS)) u_rf (
        .clock (clock),
        .reset (reset),
        .we    (reg_we),
        .waddr (reg_waddr),
        .wdata (reg_wdata),
        .raddr (ins.operand[IDX_W-1:0]),
        .rdata (rdata)
    );

    assign bus.instr_ready = reset && (state == FETCH_OP || state == FETCH_IMM);
    assign accept          = bus.instr_valid && bus.instr_ready;
    assign busy            = (state != FETCH_OP);

    // Only the low result byte and the carry/neg flags matter here.
    logic unused_alu;
    assign unused_alu = ^{bus.alu_out[15:8], bus.alu_flags[SPARE_FLAG], bus.alu_flags[ZERO_FLAG]};

    always_ff @(posedge clock) begin
        if (!reset) begin
            state             <= FETCH_OP;
            pend_op           <= '0;
            acc               <= ACC_INIT;
            flags             <= '0;
            bus.alu_x         <= '0;
            bus.alu_y         <= '0;
            bus.alu_operation <= '0;
            done              <= 1'b0;
            illegal           <= 1'b0;
        end else begin
            done    <= 1'b0;
            illegal <= 1'b0;
            case (state)
                FETCH_OP: if (accept) begin
                    if (is_illegal(ins.opcode)) begin
                        illegal <= 1'b1;
                    end else if (is_imm(ins.opcode)) begin
                        pend_op <= ins.opcode;
                        state   <= FETCH_IMM;
                    end else begin
                        // rdata is the pre-write value even if reg_we hits this index now.
                        bus.alu_x         <= acc;
                        bus.alu_y         <= rdata;
                        bus.alu_operation <= ins.opcode;
                        state             <= EXECUTE;
                    end
                end
                FETCH_IMM: if (accept) begin
                    bus.alu_x         <= acc;
                    bus.alu_y         <= bus.instr_data;
                    bus.alu_operation <= pend_op;
                    state             <= EXECUTE;
                end
                EXECUTE: state <= WRITEBACK;
                default: begin
                    acc               <= bus.alu_out[7:0];
                    flags[CARRY_FLAG] <= bus.alu_flags[CARRY_FLAG];
                    flags[NEG_FLAG]   <= bus.alu_flags[NEG_FLAG];
                    flags[ZERO_FLAG]  <= (bus.alu_out[7:0] == 8'h00);
                    flags[SPARE_FLAG] <= 1'b0;
                    done              <= 1'b1;
                    state             <= FETCH_OP;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed bench for alu_issue_unit with a small behavioural ALU attached.
module tb_alu_issue_unit;

    logic       clock = 1'b0;
    logic       reset;
    logic       reg_we;
    logic [1:0] reg_waddr;
    logic [7:0] reg_wdata;
    logic [7:0] acc;
    logic [3:0] flags;
    logic       done, illegal, busy;

    int passed = 0;
    int total  = 0;

    alu_issue_unit_if bus ();

    alu_issue_unit #(.NUM_REGS(4), .ACC_INIT(8'h00)) dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus),
        .reg_we    (reg_we),
        .reg_waddr (reg_waddr),
        .reg_wdata (reg_wdata),
        .acc       (acc),
        .flags     (flags),
        .done      (done),
        .illegal   (illegal),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    // External ALU: zero flag deliberately left 0 and spare bit set to 1 so the
    // unit's own zero computation and spare clearing are exercised.
    logic [8:0] alu_r;
    always_comb begin
        alu_r = '0;
        case (bus.alu_operation[3:1])
            3'd0: alu_r = {1'b0, bus.alu_x} + {1'b0, bus.alu_y};
            3'd1: alu_r = {1'b0, bus.alu_x} - {1'b0, bus.alu_y};
            3'd2: alu_r = {1'b0, ~bus.alu_x};
            3'd3: alu_r = {1'b0, bus.alu_x & bus.alu_y};
            3'd4: alu_r = {1'b0, bus.alu_x | bus.alu_y};
            3'd5: alu_r = {1'b0, bus.alu_x ^ bus.alu_y};
            default: alu_r = '0;
        endcase
        bus.alu_out   = {7'b0, alu_r};
        bus.alu_flags = {1'b1, alu_r[7], 1'b0, alu_r[8]};
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic send(input logic [7:0] b);
        bus.instr_valid = 1'b1;
        bus.instr_data  = b;
        step();
        bus.instr_valid = 1'b0;
    endtask

    initial begin
        reset           = 1'b0;
        bus.instr_valid = 1'b0;
        bus.instr_data  = 8'h00;
        reg_we          = 1'b0;
        reg_waddr       = 2'd0;
        reg_wdata       = 8'h00;

        step(); step();
        chk("rst_acc",   16'(acc), 16'h0000);
        chk("rst_flags", 16'(flags), 16'h0000);
        chk("rst_done",  16'(done), 16'h0000);
        chk("rst_ill",   16'(illegal), 16'h0000);
        chk("rst_ready", 16'(bus.instr_ready), 16'h0000);
        chk("rst_x",     16'(bus.alu_x), 16'h0000);
        chk("rst_y",     16'(bus.alu_y), 16'h0000);
        chk("rst_op",    16'(bus.alu_operation), 16'h0000);
        chk("rst_busy",  16'(busy), 16'h0000);

        // Release reset while loading r1 = 0x0F.
        reset = 1'b1; reg_we = 1'b1; reg_waddr = 2'd1; reg_wdata = 8'h0F;
        step();
        reg_we = 1'b0;
        chk("idle_ready", 16'(bus.instr_ready), 16'h0001);

        // SMI 0xFF
        send(8'h10);
        chk("imm_busy",  16'(busy), 16'h0001);
        chk("imm_ready", 16'(bus.instr_ready), 16'h0001);
        send(8'hFF);
        chk("ex_ready", 16'(bus.instr_ready), 16'h0000);
        chk("ex_y",     16'(bus.alu_y), 16'h00FF);
        chk("ex_op",    16'(bus.alu_operation), 16'h0001);
        chk("ex_done",  16'(done), 16'h0000);
        step();
        chk("wb_done",  16'(done), 16'h0000);
        step();
        chk("smi1_done",  16'(done), 16'h0001);
        chk("smi1_acc",   16'(acc), 16'h00FF);
        chk("smi1_flags", 16'(flags), 16'h0004);
        step();
        chk("smi1_done_low", 16'(done), 16'h0000);

        // SMI 0x01: 0xFF + 1 wraps
        send(8'h10); send(8'h01); step(); step();
        chk("wrap_acc",   16'(acc), 16'h0000);
        chk("wrap_flags", 16'(flags), 16'h0003);

        // acc = 0xF0, then ANR r1
        send(8'h10); send(8'hF0); step(); step();
        chk("f0_acc", 16'(acc), 16'h00F0);
        send(8'h61);
        chk("anr_y",  16'(bus.alu_y), 16'h000F);
        chk("anr_x",  16'(bus.alu_x), 16'h00F0);
        chk("anr_op", 16'(bus.alu_operation), 16'h0006);
        step(); step();
        chk("anr_acc",   16'(acc), 16'h0000);
        chk("anr_flags", 16'(flags), 16'h0002);
        chk("anr_done",  16'(done), 16'h0001);

        // Illegal opcode
        send(8'hC3);
        chk("ill_pulse", 16'(illegal), 16'h0001);
        chk("ill_ready", 16'(bus.instr_ready), 16'h0001);
        chk("ill_busy",  16'(busy), 16'h0000);
        chk("ill_acc",   16'(acc), 16'h0000);
        chk("ill_flags", 16'(flags), 16'h0002);
        step();
        chk("ill_low",  16'(illegal), 16'h0000);
        chk("ill_done", 16'(done), 16'h0000);

        // Stall in FETCH_IMM for 5 cycles
        send(8'h10);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_state", 16'({busy, bus.instr_ready, done}), 16'h0006);
        end
        send(8'h05); step(); step();
        chk("stall_acc",   16'(acc), 16'h0005);
        chk("stall_flags", 16'(flags), 16'h0000);
        chk("stall_done",  16'(done), 16'h0001);

        // Same-index write during capture: y takes the old r1
        reg_we = 1'b1; reg_waddr = 2'd1; reg_wdata = 8'h20;
        send(8'h01);
        reg_we = 1'b0;
        chk("wc_y_old", 16'(bus.alu_y), 16'h000F);
        step(); step();
        chk("wc_acc1", 16'(acc), 16'h0014);
        send(8'h01);
        chk("wc_y_new", 16'(bus.alu_y), 16'h0020);
        step(); step();
        chk("wc_acc2", 16'(acc), 16'h0034);

        // Reset during EXECUTE aborts with no writeback
        send(8'h01);
        chk("ab_busy", 16'(busy), 16'h0001);
        reset = 1'b0;
        step();
        chk("ab_acc",   16'(acc), 16'h0000);
        chk("ab_flags", 16'(flags), 16'h0000);
        chk("ab_ready", 16'(bus.instr_ready), 16'h0000);
        chk("ab_busy0", 16'(busy), 16'h0000);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("ab_no_done", 16'(done), 16'h0000);
        end
        chk("ab_idle", 16'({busy, bus.instr_ready}), 16'h0001);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
